// File: rtl/snes_pad_scanner.sv
// Serial game-pad scanner: drives latch/pulse, shifts in 16 bits, publishes the 8-bit button vector.
// Optional scan-to-scan debounce is enabled by defining SNES_PAD_DEBOUNCE_EN.
module snes_pad_scanner #(
    parameter int unsigned CLK_DIV     = 200,
    parameter int unsigned POLL_PERIOD = 550000
) (
    input  logic        I_CLK,
    input  logic        I_RESET,
    input  logic        I_POLL_REQ,
    input  logic        I_DATA,
    output logic        O_LATCH,
    output logic        O_PULSE,
    output logic [15:0] O_RAW,
    output logic [7:0]  O_BUTTONS,
    output logic        O_VALID,
    output logic        O_PRESS,
    output logic        O_BUSY
);

    localparam int unsigned DIV_W  = $clog2(2 * CLK_DIV);
    localparam int unsigned POLL_W = $clog2(POLL_PERIOD);

    localparam logic [DIV_W-1:0]  LATCH_LOAD = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  PHASE_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [POLL_W-1:0] POLL_LOAD  = POLL_W'(POLL_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [3:0]        idx_q, idx_d;
    logic [15:0]       shift_q, shift_d;
    logic              pending_q, pending_d;
    logic [POLL_W-1:0] poll_q, poll_d;
    logic [15:0]       raw_q, raw_d;
    logic [7:0]        buttons_q, buttons_d;
    logic              valid_q, valid_d;
    logic              press_q, press_d;
    logic              meta_q, sync_q;
    logic              publish;
    logic [7:0]        new_buttons;
`ifdef SNES_PAD_DEBOUNCE_EN
    logic [15:0]       prev_q, prev_d;
`endif

    function automatic logic [7:0] map_buttons(input logic [15:0] r);
        // {start, select, b, a, down, up, left, right}
        return {r[3], r[2], r[0], r[8], r[5], r[4], r[6], r[7]};
    endfunction

    assign new_buttons = map_buttons(shift_q);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d   = state_q;
        div_d     = div_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        pending_d = pending_q;
        poll_d    = (poll_q == '0) ? POLL_LOAD : poll_q - POLL_W'(1);
        raw_d     = raw_q;
        buttons_d = buttons_q;
        valid_d   = 1'b0;
        press_d   = 1'b0;
        publish   = 1'b0;
`ifdef SNES_PAD_DEBOUNCE_EN
        prev_d    = prev_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    pending_d = 1'b0;
                    idx_d     = 4'd0;
                    div_d     = LATCH_LOAD;
                    state_d   = S_LATCH;
                end
            end
            S_LATCH: begin
                if (div_q == '0) begin
                    div_d   = PHASE_LOAD;
                    state_d = S_LOW;
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            S_LOW: begin
                if (div_q == '0) begin
                    shift_d[idx_q] = ~sync_q;
                    div_d          = PHASE_LOAD;
                    state_d        = S_HIGH;
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            S_HIGH: begin
                if (div_q == '0) begin
                    if (idx_q == 4'd15) begin
                        // Publish registers load here so they are visible during the DONE cycle.
                        state_d = S_DONE;
`ifdef SNES_PAD_DEBOUNCE_EN
                        prev_d  = shift_q;
                        publish = (shift_q == prev_q) && (shift_q != raw_q);
`else
                        publish = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        div_d   = PHASE_LOAD;
                        state_d = S_LOW;
                    end
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (publish) begin
            raw_d     = shift_q;
            buttons_d = new_buttons;
            valid_d   = 1'b1;
            press_d   = |(new_buttons & ~buttons_q);
        end

        // Setting wins over the IDLE clear so a request in that cycle is never dropped.
        if (I_POLL_REQ || (poll_q == '0)) begin
            pending_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            pending_q <= 1'b1;
            poll_q    <= POLL_LOAD;
            raw_q     <= '0;
            buttons_q <= '0;
            valid_q   <= 1'b0;
            press_q   <= 1'b0;
            meta_q    <= 1'b1;
            sync_q    <= 1'b1;
`ifdef SNES_PAD_DEBOUNCE_EN
            prev_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            pending_q <= pending_d;
            poll_q    <= poll_d;
            raw_q     <= raw_d;
            buttons_q <= buttons_d;
            valid_q   <= valid_d;
            press_q   <= press_d;
            meta_q    <= I_DATA;
            sync_q    <= meta_q;
`ifdef SNES_PAD_DEBOUNCE_EN
            prev_q    <= prev_d;
`endif
        end
    end

    // Pad strobes decode straight from the state register so reset drops them without a clock.
    assign O_LATCH   = (state_q == S_LATCH);
    assign O_PULSE   = (state_q == S_HIGH);
    assign O_BUSY    = (state_q != S_IDLE);
    assign O_RAW     = raw_q;
    assign O_BUTTONS = buttons_q;
    assign O_VALID   = valid_q;
    assign O_PRESS   = press_q;

endmodule
